// File: rtl/page_walker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : page_walker
//  Purpose  : Hardware page-table walker sitting behind the TLB/STLB miss
//             outputs. Accepts one missing (va, pcid), walks an NLEVEL radix
//             page table through a single-outstanding req/resp memory port
//             and either pulses a one-cycle TLB fill (insert) or a one-cycle
//             fault.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n          clock (rising edge), asynchronous active-low reset
//    shutdown            synchronous abort of any walk in progress
//    miss_valid/ready    miss handshake; miss_va, miss_pcid captured on accept
//    ptbr                root table base (page aligned, low bits ignored)
//    mem_req_*           PTE read request (valid/ready, 8-byte aligned addr)
//    mem_resp_*          one PTE beat per accepted request
//    insert, ins_*       one-cycle fill pulse with va/pa/pcid
//    fault               one-cycle walk-failure pulse
//    busy                walk in progress
// ============================================================================
module page_walker #(
    parameter int SADDR  = 64,
    parameter int SPAGE  = 12,
    parameter int SPCID  = 12,
    parameter int NLEVEL = 4,
    parameter int SIDX   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shutdown,
    input  logic             miss_valid,
    output logic             miss_ready,
    input  logic [SADDR-1:0] miss_va,
    input  logic [SPCID-1:0] miss_pcid,
    input  logic [SADDR-1:0] ptbr,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [SADDR-1:0] mem_req_addr,
    input  logic             mem_resp_valid,
    input  logic [63:0]      mem_resp_data,
    output logic             insert,
    output logic [SADDR-1:0] ins_va,
    output logic [SADDR-1:0] ins_pa,
    output logic [SPCID-1:0] ins_pcid,
    output logic             fault,
    output logic             busy
);

    localparam int             LVW     = (NLEVEL > 1) ? $clog2(NLEVEL) : 1;
    localparam logic [LVW-1:0] LVL_TOP = LVW'(NLEVEL - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t           state_q;
    logic [LVW-1:0]   level_q;
    logic             drop_q;
    logic             mem_req_valid_q;
    logic [SADDR-1:0] mem_req_addr_q;
    logic             insert_q;
    logic             fault_q;
    logic             busy_q;
    logic [SADDR-1:0] ins_va_q;
    logic [SADDR-1:0] ins_pa_q;
    logic [SPCID-1:0] ins_pcid_q;

    // Byte offset of the PTE selected by the VA index field of a level.
    function automatic logic [SADDR-1:0] pte_offset(input logic [SADDR-1:0] va,
                                                    input logic [LVW-1:0]   lvl);
        logic [SADDR-1:0] sh;
        sh = va >> (SPAGE + SIDX * int'(lvl));
        return {{(SADDR-SIDX){1'b0}}, sh[SIDX-1:0]} << 3;
    endfunction

    // Next-state values for the request address and the leaf translation.
    logic [SADDR-1:0] root_addr_d;
    logic [SADDR-1:0] next_addr_d;
    logic [SADDR-1:0] leaf_pa_d;
    logic             pte_v;
    logic             pte_l;
    logic             last_lvl;
    logic             pte_bad;

    assign root_addr_d = {ptbr[SADDR-1:SPAGE], {SPAGE{1'b0}}}
                       + pte_offset(miss_va, LVL_TOP);
    assign next_addr_d = {mem_resp_data[SADDR-1:SPAGE], {SPAGE{1'b0}}}
                       + pte_offset(ins_va_q, level_q - LVW'(1));
    assign leaf_pa_d   = {mem_resp_data[SADDR-1:SPAGE], ins_va_q[SPAGE-1:0]};

    assign pte_v    = mem_resp_data[0];
    assign pte_l    = mem_resp_data[1];
    assign last_lvl = (level_q == '0);
    // Only a leaf at level 0 and a pointer above level 0 are legal.
    assign pte_bad  = !pte_v || (pte_l != last_lvl);

    // Gated with rst_n so the handshake is closed while reset is held, yet
    // opens in the very first cycle after release.
    assign miss_ready = rst_n && (state_q == S_IDLE) && !drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            level_q         <= LVL_TOP;
            drop_q          <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            insert_q        <= 1'b0;
            fault_q         <= 1'b0;
            busy_q          <= 1'b0;
            ins_va_q        <= '0;
            ins_pa_q        <= '0;
            ins_pcid_q      <= '0;
        end else begin
            insert_q <= 1'b0;
            fault_q  <= 1'b0;

            // A response orphaned by shutdown is swallowed here.
            if (drop_q && mem_resp_valid) begin
                drop_q <= 1'b0;
            end

            if (shutdown) begin
                // If the response lands in the same cycle it is consumed
                // now, so there is nothing left to drop.
                if (state_q == S_WAIT && !mem_resp_valid) begin
                    drop_q <= 1'b1;
                end
                state_q         <= S_IDLE;
                mem_req_valid_q <= 1'b0;
                busy_q          <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (miss_valid && miss_ready) begin
                            ins_va_q        <= miss_va;
                            ins_pcid_q      <= miss_pcid;
                            level_q         <= LVL_TOP;
                            mem_req_addr_q  <= root_addr_d;
                            mem_req_valid_q <= 1'b1;
                            busy_q          <= 1'b1;
                            state_q         <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (mem_req_ready) begin
                            mem_req_valid_q <= 1'b0;
                            state_q         <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (mem_resp_valid) begin
                            if (pte_bad) begin
                                fault_q <= 1'b1;
                                state_q <= S_FAULT;
                            end else if (!pte_l) begin
                                level_q         <= level_q - LVW'(1);
                                mem_req_addr_q  <= next_addr_d;
                                mem_req_valid_q <= 1'b1;
                                state_q         <= S_REQ;
                            end else begin
                                ins_pa_q <= leaf_pa_d;
                                insert_q <= 1'b1;
                                state_q  <= S_DONE;
                            end
                        end
                    end
                    S_DONE, S_FAULT: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        mem_req_valid_q <= 1'b0;
                        busy_q          <= 1'b0;
                        state_q         <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign insert        = insert_q;
    assign fault         = fault_q;
    assign busy          = busy_q;
    assign ins_va        = ins_va_q;
    assign ins_pa        = ins_pa_q;
    assign ins_pcid      = ins_pcid_q;

    // PTE flag bits 11:2, any PTE bits above SADDR and the page-offset bits
    // of ptbr carry no meaning for the walk.
    logic unused_ok;
    assign unused_ok = ^{ptbr, mem_resp_data};

endmodule
`default_nettype wire

// File: tb/tb_page_walker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_page_walker
//  Purpose  : Self-checking bench for page_walker. A sparse memory holds the
//             page table; a reference walk over that memory predicts request
//             addresses and the final outcome of every miss.
//  Revision : 1.0  initial release
// ============================================================================
module tb_page_walker;

    localparam int SADDR  = 64;
    localparam int SPAGE  = 12;
    localparam int SPCID  = 12;
    localparam int NLEVEL = 4;
    localparam int SIDX   = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             shutdown = 1'b0;
    logic             miss_valid = 1'b0;
    logic             miss_ready;
    logic [SADDR-1:0] miss_va = '0;
    logic [SPCID-1:0] miss_pcid = '0;
    logic [SADDR-1:0] ptbr = '0;
    logic             mem_req_valid;
    logic             mem_req_ready = 1'b0;
    logic [SADDR-1:0] mem_req_addr;
    logic             mem_resp_valid = 1'b0;
    logic [63:0]      mem_resp_data = '0;
    logic             insert;
    logic [SADDR-1:0] ins_va;
    logic [SADDR-1:0] ins_pa;
    logic [SPCID-1:0] ins_pcid;
    logic             fault;
    logic             busy;

    always #5 clk = ~clk;

    page_walker #(
        .SADDR (SADDR),
        .SPAGE (SPAGE),
        .SPCID (SPCID),
        .NLEVEL(NLEVEL),
        .SIDX  (SIDX)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .shutdown      (shutdown),
        .miss_valid    (miss_valid),
        .miss_ready    (miss_ready),
        .miss_va       (miss_va),
        .miss_pcid     (miss_pcid),
        .ptbr          (ptbr),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .insert        (insert),
        .ins_va        (ins_va),
        .ins_pa        (ins_pa),
        .ins_pcid      (ins_pcid),
        .fault         (fault),
        .busy          (busy)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] mem [logic [63:0]];
    logic [63:0] pt_root = '0;
    logic [63:0] exp_addr [$];
    bit          exp_ok;
    logic [63:0] exp_pa;
    logic [63:0] rva;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    // Reference walk: follows the table in mem from pt_root for va.
    task automatic model(input logic [63:0] va);
        logic [63:0] base, a, pte;
        exp_addr.delete();
        exp_ok = 1'b0;
        exp_pa = '0;
        base   = pt_root & ~64'hFFF;
        for (int lvl = NLEVEL - 1; lvl >= 0; lvl--) begin
            a = base + ((va >> (SPAGE + SIDX * lvl)) % (1 << SIDX)) * 8;
            exp_addr.push_back(a);
            pte = mem_rd(a);
            if (!pte[0]) return;
            if (pte[1] != (lvl == 0)) return;
            base = pte & ~64'hFFF;
            if (lvl == 0) begin
                exp_ok = 1'b1;
                exp_pa = base | (va & 64'hFFF);
            end
        end
    endtask

    // Random table along the path of va; bad_pct percent of PTEs get random flags.
    task automatic build_table(input logic [63:0] va, input int bad_pct);
        logic [63:0] base, a, ppn;
        logic [1:0]  fl;
        mem.delete();
        base = pt_root & ~64'hFFF;
        for (int lvl = NLEVEL - 1; lvl >= 0; lvl--) begin
            a   = base + ((va >> (SPAGE + SIDX * lvl)) % (1 << SIDX)) * 8;
            ppn = {$urandom, $urandom} & ~64'hFFF;
            fl  = (lvl == 0) ? 2'b11 : 2'b01;
            if ($urandom_range(99) < bad_pct) fl = 2'($urandom);
            mem[a] = ppn | 64'($urandom & 32'hFFC) | {62'b0, fl};
            base   = ppn;
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!miss_ready && k < 50) begin
            step();
            k++;
        end
        check("ready_wait", miss_ready, 1);
    endtask

    // One miss from handshake to outcome. stall = cycles of mem_req_ready=0
    // per request; shut_req >= 0 aborts with shutdown in the WAIT of that request.
    task automatic walk(input logic [63:0] va, input logic [11:0] pcid,
                        input int stall, input int shut_req);
        int          c, nreq, nacc, scnt;
        bit          in_req, resp_pend, done, got_ins, got_flt;
        logic [63:0] cur_addr, resp_d;
        model(va);
        c = 0; nreq = 0; nacc = 0; scnt = 0;
        in_req = 0; resp_pend = 0; done = 0; got_ins = 0; got_flt = 0;
        cur_addr = '0; resp_d = '0;
        wait_ready();
        ptbr       = pt_root;
        miss_valid = 1'b1;
        miss_va    = va;
        miss_pcid  = pcid;
        step();
        miss_valid = 1'b0;
        miss_va    = ~va;
        miss_pcid  = ~pcid;
        ptbr       = {$urandom, $urandom};
        while (!done && c < 300) begin
            c++;
            if (c == 1) begin
                check("busy_start", busy, 1);
                check("ready_busy", miss_ready, 0);
            end
            mem_resp_valid = 1'b0;
            mem_resp_data  = {$urandom, $urandom};
            shutdown       = 1'b0;
            if (resp_pend) begin
                resp_pend = 0;
                if (nacc - 1 == shut_req) begin
                    shutdown = 1'b1;
                    done     = 1;
                end else begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = resp_d;
                end
            end
            if (insert) begin
                got_ins = 1;
                done    = 1;
                check("ins_cycle", c, 9 + 4 * stall);
                check("ins_va", ins_va, va);
                check("ins_pcid", ins_pcid, pcid);
                check("ins_pa", ins_pa, exp_pa);
                check("ins_busy", busy, 1);
            end
            if (fault) begin
                got_flt = 1;
                done    = 1;
                check("flt_busy", busy, 1);
            end
            if (mem_req_valid) begin
                if (!in_req) begin
                    in_req   = 1;
                    scnt     = 0;
                    cur_addr = mem_req_addr;
                    if (nreq < exp_addr.size()) check("req_addr", mem_req_addr, exp_addr[nreq]);
                    else check("req_extra", nreq, exp_addr.size());
                    nreq++;
                end else begin
                    check("req_stable", mem_req_addr, cur_addr);
                end
                mem_req_ready = (scnt >= stall);
                scnt++;
                if (mem_req_ready) begin
                    in_req    = 0;
                    nacc++;
                    resp_pend = 1;
                    resp_d    = mem_rd(cur_addr);
                end
            end else begin
                mem_req_ready = 1'($urandom_range(1));
            end
            step();
        end
        if (!done) check("walk_timeout", 0, 1);
        shutdown       = 1'b0;
        mem_resp_valid = 1'b0;
        if (shut_req < 0) begin
            check("insert_seen", got_ins, exp_ok);
            check("fault_seen", got_flt, !exp_ok);
            check("req_count", nreq, exp_addr.size());
            check("pulse_end", {insert, fault, busy}, 0);
        end else begin
            check("shut_quiet", got_ins | got_flt, 0);
            for (int i = 1; i <= 3; i++) begin
                check("drop_ready", miss_ready, 0);
                check("drop_out", {insert, fault, busy}, 0);
                if (i == 3) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = 64'h5003;
                end
                step();
            end
            mem_resp_valid = 1'b0;
            check("drop_clear", miss_ready, 1);
        end
    endtask

    task automatic load_success_table();
        mem[64'h1FF8] = 64'h2001;
        mem[64'h2FF8] = 64'h3001;
        mem[64'h3FF8] = 64'h4001;
        mem[64'h4FF8] = 64'h5003;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_ready", miss_ready, 0);
        check("rst_outs", {insert, fault, mem_req_valid, busy}, 0);
        check("rst_addr", mem_req_addr, 0);
        check("rst_insva", ins_va, 0);
        check("rst_inspa", ins_pa, 0);
        check("rst_pcid", ins_pcid, 0);
        rst_n = 1'b1;
        #1;
        check("rel_ready0", miss_ready, 1);
        step();

        // Successful walk, zero-wait memory
        pt_root = 64'h1000;
        mem.delete();
        load_success_table();
        walk(64'hFFFF_FFFF_FFFF_F123, 12'd1, 0, -1);

        // Invalid PTE at level 2
        mem.delete();
        mem[64'h1FF8] = 64'h2001;
        walk(64'hFFFF_FFFF_FFFF_F123, 12'd3, 0, -1);

        // Leaf at level 3
        mem.delete();
        mem[64'h1FF8] = 64'h2003;
        walk(64'hFFFF_FFFF_FFFF_F123, 12'd4, 0, -1);

        // Backpressure: 5 stall cycles per level
        mem.delete();
        load_success_table();
        walk(64'hFFFF_FFFF_FFFF_F123, 12'd5, 5, -1);

        // Shutdown during level-1 WAIT, then a fresh walk at va=0
        walk(64'hFFFF_FFFF_FFFF_F123, 12'd6, 0, 2);
        mem[64'h1000] = 64'h2001;
        mem[64'h2000] = 64'h3001;
        mem[64'h3000] = 64'h4001;
        mem[64'h4000] = 64'h5003;
        walk(64'h0, 12'd2, 0, -1);

        // Asynchronous reset while a request is pending
        wait_ready();
        ptbr          = pt_root;
        miss_valid    = 1'b1;
        miss_va       = 64'hFFFF_FFFF_FFFF_F123;
        miss_pcid     = 12'd7;
        mem_req_ready = 1'b0;
        step();
        miss_valid = 1'b0;
        check("arst_pre", mem_req_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_reqv", mem_req_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", miss_ready, 0);
        check("arst_addr", mem_req_addr, 0);
        check("arst_ins", {ins_va, ins_pa[3:0]}, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("arel_ready", miss_ready, 1);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h5003;
        step();
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("arel_quiet", {insert, fault, busy}, 0);
            step();
        end

        // Randomized walks over random tables
        for (int t = 0; t < 40; t++) begin
            pt_root = {$urandom, $urandom};
            rva     = {$urandom, $urandom};
            build_table(rva, 12);
            walk(rva, 12'($urandom), int'($urandom_range(3)), -1);
            mem_resp_valid = 1'b1;
            mem_resp_data  = {$urandom, $urandom};
            step();
            mem_resp_valid = 1'b0;
            check("idle_noise", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/page_walker.md
Name: page_walker

Overview:
- Hardware page-table walker downstream of the TLB/STLB miss outputs.
- Accepts a missing (va, pcid) and walks a 4-level radix page table in memory through a req/resp port.
- On success it returns the translation to the TLB/STLB fill path as a one-cycle insert pulse with va/pa/pcid.
- On failure it pulses fault and inserts nothing.

Parameters:
- SADDR, 64, virtual/physical address width.
- SPAGE, 12, page offset bits.
- SPCID, 12, PCID width.
- NLEVEL, 4, page-table levels.
- SIDX, 9, VA index bits per level; requires SPAGE+NLEVEL*SIDX <= SADDR.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- shutdown  in  1  synchronous abort/flush, active-high.
- miss_valid  in  1  miss request present.
- miss_ready  out  1  walker can accept a miss.
- miss_va  in  SADDR  faulting virtual address.
- miss_pcid  in  SPCID  PCID of the miss.
- ptbr  in  SADDR  root table physical base; low SPAGE bits ignored.
- mem_req_valid  out  1  PTE read request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  SADDR  PTE physical address, 8-byte aligned.
- mem_resp_valid  in  1  PTE data valid, one beat per request.
- mem_resp_data  in  64  PTE.
- insert  out  1  one-cycle fill pulse to TLB/STLB.
- ins_va  out  SADDR  captured miss_va.
- ins_pa  out  SADDR  translated address.
- ins_pcid  out  SPCID  captured miss_pcid.
- fault  out  1  one-cycle walk-failure pulse.
- busy  out  1  walk in progress (state != IDLE).

Behaviour:
- Reset (rst_n=0, async): state=IDLE, level=NLEVEL-1.
  - Outputs: insert=0, fault=0, mem_req_valid=0, mem_req_addr=0, ins_va=0, ins_pa=0, ins_pcid=0, busy=0, miss_ready=0 while rst_n=0.
  - miss_ready=1 in the first IDLE cycle after release.
- States: IDLE, REQ, WAIT, DONE, FAULT.
- IDLE:
  - miss_ready=1.
  - On miss_valid&miss_ready: capture va, pcid, and base={ptbr[SADDR-1:SPAGE], SPAGE'b0}; set level=NLEVEL-1; go to REQ.
- REQ:
  - mem_req_valid=1.
  - mem_req_addr = base + (idx<<3), where idx = va[SPAGE+SIDX*(level+1)-1 : SPAGE+SIDX*level], zero-extended; addition is modulo 2^SADDR.
  - Address is held stable until mem_req_ready.
  - On valid&ready go to WAIT.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid, evaluate the PTE. PTE format: bit0=V, bit1=L (leaf), bits[SADDR-1:SPAGE]=PPN.
  - V=0 -> FAULT.
  - L=1 at level>0 -> FAULT (no superpages).
  - L=0 at level=0 -> FAULT.
  - L=0 at level>0 -> base={PPN, SPAGE'b0}, level-1, go to REQ.
  - L=1 at level=0 -> ins_pa={PPN, va[SPAGE-1:0]}, go to DONE.
- DONE: insert=1 for exactly one cycle, with ins_va/ins_pcid = captured values; next state IDLE.
- FAULT: fault=1 for exactly one cycle, insert stays 0; next state IDLE.
- ins_va/ins_pa/ins_pcid hold their last value until the next capture.
- Latency, with zero-wait memory (ready=1, resp one cycle after accept):
  - Accept in cycle 0; level-3 request in cycle 1; 2 cycles per level.
  - insert asserted in cycle 9 for NLEVEL=4.
- Single outstanding request only. miss_ready=0 in every state except IDLE, so a new miss is never accepted while busy.
- mem_resp_valid in IDLE/REQ/DONE/FAULT is ignored, except for the drop described under shutdown.
- shutdown (sampled on clk) in any state:
  - Next state IDLE; insert/fault not asserted.
  - If asserted in WAIT, set drop flag; the next mem_resp_valid is discarded and clears drop.
  - miss_ready=0 while drop is set.
  - shutdown together with miss_valid in IDLE: miss is not accepted.
- rst_n assertion mid-walk: immediate return to the reset state; any pending response after release is ignored because state is IDLE.

Test Plan:
- Walk success:
  - Stimulus: ptbr=0x1000, va=0xFFFF_FFFF_FFFF_F123, pcid=1; memory returns non-leaf PTEs 0x2001, 0x3001, 0x4001, then leaf 0x5003.
  - Required: request addrs 0x1FF8, 0x2FF8, 0x3FF8, 0x4FF8; single insert pulse at cycle 9 with ins_pa=0x5123, ins_pcid=1, ins_va=miss_va.
- Invalid PTE: level-2 PTE=0x0 -> fault pulse 1 cycle, insert never high, busy falls the cycle after fault.
- Early leaf: level-3 PTE=0x2003 -> fault; no further mem_req.
- Backpressure:
  - Stimulus: mem_req_ready=0 for 5 cycles at each level.
  - Required: mem_req_addr stable while valid; insert delayed by exactly 20 cycles vs. zero-wait.
- Shutdown in WAIT:
  - Stimulus: shutdown during level-1 WAIT; stale response arrives 3 cycles later; a new miss with va=0x0, pcid=2 is presented.
  - Required: stale response is dropped; miss_ready stays 0 until it arrives; the new walk then completes with correct ins_pcid=2.
- Async reset mid-REQ: rst_n=0 between clock edges -> mem_req_valid and busy drop immediately; after release, miss_ready=1 and no insert/fault.
